mul_pipe: RTL
=============

# mul_pipe

Parametrised pipelined fixed-point multiplier with valid/ready flow control, signed/unsigned mode, optional round-to-nearest and compile-time saturation. It is the general multiply primitive for the math datapath. Arithmetic units that need backpressure, a configurable pipeline depth or a non-16.16 format instantiate it instead of the single-cycle multipliers.

## Interface
- WIDTH_A, 16: operand A width.
- WIDTH_B, 16: operand B width.
- FRAC_BITS, 8: LSBs dropped from the full product (0 to WIDTH_A+WIDTH_B-1).
- OUT_WIDTH, 16: result width (1 to WIDTH_A+WIDTH_B-FRAC_BITS).
- STAGES, 2: pipeline register stages (≥1); equals latency.
- SIGNED, 1: 1 = two's-complement operands and result; 0 = unsigned.
- ROUND, 0: 1 = round half up before the shift (requires FRAC_BITS≥1); 0 = truncate.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- din_a  in  WIDTH_A  operand A.
- din_b  in  WIDTH_B  operand B.
- din_valid  in  1  operands valid.
- din_ready  out  1  block accepts operands this cycle.
- dout  out  OUT_WIDTH  result.
- dout_valid  out  1  result valid.
- dout_ready  in  1  consumer accepts result this cycle.
- dout_ovf  out  1  result was clamped (saturation build only).

## Operation
- Input transfer occurs when din_valid && din_ready. Output transfer occurs when dout_valid && dout_ready.
- Full product P = din_a*din_b is WIDTH_A+WIDTH_B bits, signed when SIGNED=1.
- If ROUND=1, add 2^(FRAC_BITS-1) to P. No overflow is possible because P is held one bit wider internally.
- R = P >> FRAC_BITS. The shift is arithmetic when SIGNED=1 and logical otherwise.
- R is range-reduced to OUT_WIDTH (see Configuration).
- The final value enters stage 0 on input transfer and advances through stages 1..STAGES-1. dout and dout_valid are the last stage's registers.
- Each stage k has a valid bit v[k]. Stage k loads when !v[k] or stage k+1 loads; the last stage counts as loading when !v[last] or dout_ready.
- Bubbles collapse: an empty stage always accepts from upstream.
- din_ready equals stage 0's load condition. It is combinational from dout_ready through the chain.
- A stage that is not loading holds its data and valid bit.
- A stage that loads from an empty upstream clears its valid bit and keeps stale data.
- With STAGES items in flight and dout_ready=0, din_ready=0. Items are never dropped, duplicated or reordered.
- Data remains stable while dout_valid && !dout_ready.

## Timing
- Reset values: all v[k]=0, dout=0, dout_valid=0, dout_ovf=0. din_ready=1 after reset while asserted is don't-care.
- Asserting rst clears all stages immediately, without waiting for a clock edge. In-flight items are discarded and never appear after release.
- Latency is STAGES cycles, input transfer to dout_valid, with dout_ready held high.
- Throughput is one result per cycle with dout_ready high.
- Simultaneous input and output transfer on a full pipeline is permitted: din_ready=1 when dout_ready=1.
- dout_ovf travels with its data and has the same validity as dout.

## Configuration
- MUL_SATURATE_EN defined:
  - If R exceeds the OUT_WIDTH range, clamp to the max or min representable value: signed [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1], unsigned [0, 2^OUT_WIDTH-1].
  - dout_ovf=1 with that result.
- MUL_SATURATE_EN undefined:
  - dout = R[OUT_WIDTH-1:0], wrapping on overflow.
  - dout_ovf is tied to 0 and no compare logic is built.

## Test plan
All scenarios use WIDTH_A=WIDTH_B=16, FRAC_BITS=8, OUT_WIDTH=16, SIGNED=1, unless stated otherwise.
- Basic (STAGES=3, ROUND=0): a=0x0180 (1.5), b=0x0200 (2.0), dout_ready=1 -> dout=0x0300, dout_valid exactly 3 cycles after transfer. a=0xFE80 (-1.5), b=0x0200 -> 0xFD00.
- Rounding: a=0x0001, b=0x0080 -> dout=0x0000 with ROUND=0; dout=0x0001 with ROUND=1.
- Overflow: a=0x7FFF, b=0x7FFF -> with MUL_SATURATE_EN, dout=0x7FFF and dout_ovf=1; without, dout=0xFF00 and dout_ovf=0. a=0x8000, b=0x7FFF, saturating build -> 0x8000, dout_ovf=1.
- Backpressure (STAGES=3): stream 6 operand pairs with dout_ready=0 -> din_ready drops after exactly 3 transfers. Then toggle dout_ready randomly -> all 6 results arrive in order, each held stable while stalled.
- Bubbles: a single item followed by idle cycles, then dout_ready=0 for 2 cycles -> pipeline accepts 2 more items while the first waits (bubble collapse), with no loss.
- Reset mid-flight: 2 items in flight, pulse rst between clock edges -> dout_valid=0 immediately. After release, no stale result appears and the next input yields a correct result after STAGES cycles.

Source files
------------

// File: rtl/mul_pipe.sv
// Pipelined fixed-point multiplier with valid/ready flow control and optional rounding.
// Define MUL_SATURATE_EN to clamp out-of-range results and raise dout_ovf; otherwise results wrap.
module mul_pipe #(
  parameter int WIDTH_A   = 16,
  parameter int WIDTH_B   = 16,
  parameter int FRAC_BITS = 8,
  parameter int OUT_WIDTH = 16,
  parameter int STAGES    = 2,
  parameter int SIGNED    = 1,
  parameter int ROUND     = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH_A-1:0]   din_a,
  input  logic [WIDTH_B-1:0]   din_b,
  input  logic                 din_valid,
  output logic                 din_ready,
  output logic [OUT_WIDTH-1:0] dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 dout_ovf
);

  // One spare bit so the rounding increment can never overflow the product.
  localparam int EW = WIDTH_A + WIDTH_B + 1;
  localparam int RW = EW - FRAC_BITS;

  logic [EW-1:0] a_ext, b_ext, prod, rnd;
  logic [RW-1:0] r;

  always_comb begin
    if (SIGNED != 0) begin
      a_ext = {{(EW-WIDTH_A){din_a[WIDTH_A-1]}}, din_a};
      b_ext = {{(EW-WIDTH_B){din_b[WIDTH_B-1]}}, din_b};
    end else begin
      a_ext = {{(EW-WIDTH_A){1'b0}}, din_a};
      b_ext = {{(EW-WIDTH_B){1'b0}}, din_b};
    end
  end

  assign prod = a_ext * b_ext;

  generate
    if (ROUND != 0) begin : g_round
      assign rnd = prod + (EW'(1) << (FRAC_BITS - 1));
    end else begin : g_trunc
      assign rnd = prod;
    end
  endgenerate

  // Low RW bits of either shift flavour; signedness only matters for range reduction.
  assign r = rnd[EW-1:FRAC_BITS];

`ifdef MUL_SATURATE_EN
  localparam int DW = OUT_WIDTH + 1;
  logic [OUT_WIDTH-1:0] s_max, val;
  logic                 ovf;
  logic [DW-1:0]        res;

  assign s_max = {OUT_WIDTH{1'b1}} >> 1;

  always_comb begin
    ovf = 1'b0;
    val = r[OUT_WIDTH-1:0];
    if (SIGNED != 0) begin
      if (!(&r[RW-1:OUT_WIDTH-1] || ~|r[RW-1:OUT_WIDTH-1])) begin
        ovf = 1'b1;
        val = r[RW-1] ? ~s_max : s_max;
      end
    end else if (|r[RW-1:OUT_WIDTH]) begin
      ovf = 1'b1;
      val = '1;
    end
  end

  assign res = {ovf, val};
`else
  localparam int DW = OUT_WIDTH;
  logic [DW-1:0] res;

  assign res = r[OUT_WIDTH-1:0];
`endif

  logic unused_bits;
  assign unused_bits = ^{rnd, r};

  // Handshake: a transfer happens on a rising edge where valid && ready; a stage
  // loads when it, or any stage downstream of it, is empty or the consumer is ready.
  logic [DW-1:0]     data_q [STAGES];
  logic [DW-1:0]     data_d [STAGES];
  logic [STAGES-1:0] valid_q, valid_d, load;

  for (genvar k = 0; k < STAGES; k++) begin : g_load
    assign load[k] = dout_ready || !(&valid_q[STAGES-1:k]);
  end

  always_comb begin
    valid_d = valid_q;
    for (int k = 0; k < STAGES; k++) data_d[k] = data_q[k];
    if (load[0]) begin
      valid_d[0] = din_valid;
      if (din_valid) data_d[0] = res;
    end
    for (int k = 1; k < STAGES; k++) begin
      if (load[k]) begin
        valid_d[k] = valid_q[k-1];
        if (valid_q[k-1]) data_d[k] = data_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int k = 0; k < STAGES; k++) data_q[k] <= '0;
    end else begin
      valid_q <= valid_d;
      for (int k = 0; k < STAGES; k++) data_q[k] <= data_d[k];
    end
  end

  assign din_ready  = load[0];
  assign dout_valid = valid_q[STAGES-1];
  assign dout       = data_q[STAGES-1][OUT_WIDTH-1:0];
`ifdef MUL_SATURATE_EN
  assign dout_ovf   = data_q[STAGES-1][OUT_WIDTH];
`else
  assign dout_ovf   = 1'b0;
`endif

endmodule
